// File: rtl/if_id_queue_pkg.sv
// Shared RISC-V front-end constants: widths, control-transfer opcodes, NOP encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package if_id_queue_pkg;

  // Architectural widths used as defaults by the fetch/decode path
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Major opcodes of the control-transfer instructions (inst[6:0])
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // addi x0, x0, 0: what decode sees when the queue has nothing to offer
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv_predecode.sv
// Predecode: flags JAL / JALR / BRANCH from the major opcode of one instruction.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module rv_predecode
  import if_id_queue_pkg::*;
(
  input  logic [ILEN-1:0] inst,
  output logic            is_ctrl
);

  logic [6:0] opcode;
  logic       unused_upper;

  assign opcode       = inst[6:0];
  // Only the opcode field decides control transfer; the rest is ignored
  assign unused_upper = ^inst[ILEN-1:7];

  // Match the three control-transfer opcodes
  always_comb begin
    is_ctrl = 1'b0;
    case (opcode)
      OPC_JAL, OPC_JALR, OPC_BRANCH: is_ctrl = 1'b1;
      default:                       is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH {pc, inst, is_ctrl} entries in program order, flushable.
// Latency: an entry written at edge N is visible on out_* right after edge N; no in->out bypass.
// Backpressure: in_ready = !full (registered count only, no path from out_ready); flush beats enq/deq.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = XLEN,
  parameter int INST_W = ILEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic                       out_is_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  ctrl_mem;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             in_is_ctrl;

  // Full and empty come only from count; pointers alone are ambiguous when equal
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // Flush suppresses both sides of the handshake in the same cycle
  assign enq = in_valid && !full && !flush;
  assign deq = out_ready && !empty && !flush;

  // Classify at enqueue so the head flag is a plain register read
  rv_predecode u_predecode (
    .inst    (in_inst[ILEN-1:0]),
    .is_ctrl (in_is_ctrl)
  );

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
      ctrl_mem[wr_ptr] <= in_is_ctrl;
    end
  end

  // Pointers and occupancy; power-of-two DEPTH makes pointer overflow the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head mux; an empty queue presents pc 0 and a NOP so reset is seen immediately
  always_comb begin
    out_pc      = '0;
    out_inst    = INST_W'(INST_NOP);
    out_is_ctrl = 1'b0;
    if (!empty) begin
      out_pc      = pc_mem[rd_ptr];
      out_inst    = inst_mem[rd_ptr];
      out_is_ctrl = ctrl_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, single pass, fill/backpressure, streaming wrap, flush, predecode, async reset.
// Inputs change 1ns after a rising edge; outputs are checked in the same window.
// All expectations are hand-computed constants for DEPTH=4.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_is_ctrl;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_is_ctrl (out_is_ctrl),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = 32'h0000_0013;

    // Reset then idle
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_inst",  64'(out_inst),  64'h13);
    chk("rst_out_pc",    out_pc,         64'd0);
    chk("rst_is_ctrl",   64'(out_is_ctrl), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_count",     64'(count),     64'd0);
    chk("idle_out_inst",  64'(out_inst),  64'h13);

    // Single pass
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'h0000_0093;
    #1;
    chk("no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("sp_out_valid", 64'(out_valid), 64'd1);
    chk("sp_out_pc",    out_pc,         64'h8000_0000);
    chk("sp_out_inst",  64'(out_inst),  64'h93);
    chk("sp_is_ctrl",   64'(out_is_ctrl), 64'd0);
    chk("sp_count",     64'(count),     64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sp_drain_count", 64'(count), 64'd0);
    chk("sp_drain_valid", 64'(out_valid), 64'd0);

    // Fill and backpressure
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 64'h8000_0000 + 64'(4 * k); in_inst = 32'h0000_0093;
      tick();
    end
    chk("fill_count",    64'(count),    64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    in_pc = 64'h8000_0010;
    tick();
    chk("full_ignore_count", 64'(count), 64'd4);
    chk("full_head_pc",      out_pc,     64'h8000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_deq_count", 64'(count), 64'd3);
    chk("full_deq_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("refill_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("drain_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // Steady stream across pointer wrap
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_pc = 64'h1000 + 64'(4 * k); in_inst = 32'h0000_0033;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 64'h1000 + 64'(4 * (i + 2));
      chk("stream_pc",    out_pc,      64'h1000 + 64'(4 * i));
      chk("stream_count", 64'(count),  64'd2);
      tick();
    end
    in_valid = 1'b0;
    chk("stream_tail0", out_pc, 64'h1028);
    tick();
    chk("stream_tail1", out_pc, 64'h102C);
    tick();
    out_ready = 1'b0;
    chk("stream_end_count", 64'(count), 64'd0);

    // Flush priority
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_pc = 64'h2000 + 64'(4 * k);
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_pc = 64'h200C; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_pc = 64'h3000;
    tick();
    in_valid = 1'b0;
    chk("post_flush_pc",    out_pc,     64'h3000);
    chk("post_flush_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Predecode
    in_valid = 1'b1; in_pc = 64'h4000; in_inst = 32'h0000_006F; tick();
    in_pc = 64'h4004; in_inst = 32'h0000_0063; tick();
    in_pc = 64'h4008; in_inst = 32'h0000_0067; tick();
    in_pc = 64'h400C; in_inst = 32'h0000_0033; tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("jal_ctrl",    64'(out_is_ctrl), 64'd1);
    chk("jal_inst",    64'(out_inst),    64'h6F);
    tick();
    chk("branch_ctrl", 64'(out_is_ctrl), 64'd1);
    chk("branch_pc",   out_pc,           64'h4004);
    tick();
    chk("jalr_ctrl",   64'(out_is_ctrl), 64'd1);
    tick();
    chk("alu_ctrl",    64'(out_is_ctrl), 64'd0);
    tick();
    out_ready = 1'b0;

    // Async reset between edges
    in_valid = 1'b1; in_pc = 64'h5000; in_inst = 32'h0000_006F; tick();
    in_pc = 64'h5004; tick();
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    64'(out_valid),   64'd0);
    chk("arst_count",    64'(count),       64'd0);
    chk("arst_in_ready", 64'(in_ready),    64'd1);
    chk("arst_inst",     64'(out_inst),    64'h13);
    chk("arst_pc",       out_pc,           64'd0);
    chk("arst_ctrl",     64'(out_is_ctrl), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage. It decouples fetch pc/inst production from decode consumption.
- Holds up to DEPTH fetched {pc, inst} pairs in program order, with valid/ready handshakes on both sides.
- Drops all buffered entries on a pipeline flush (branch/jump redirect).
- Supplies a predecode flag marking control-transfer instructions so decode and redirect logic need not re-derive the opcode.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_W, 64, pc width.
- INST_W, 32, instruction width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset. Takes effect immediately on assertion; release is synchronised externally.
- flush  input  1  discard all entries and any same-cycle enqueue.
- in_valid  input  1  fetch presents a valid pc/inst.
- in_ready  output  1  queue can accept; equals !full, with no combinational path from out_ready.
- in_pc  input  PC_W  pc of the fetched instruction.
- in_inst  input  INST_W  fetched instruction.
- out_valid  output  1  head entry present (!empty).
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  PC_W  pc of the head entry.
- out_inst  output  INST_W  instruction at the head.
- out_is_ctrl  output  1  head opcode[6:0] is JAL 7'b1101111, JALR 7'b1100111 or BRANCH 7'b1100011.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {pc, inst, is_ctrl}, with rd_ptr and wr_ptr each $clog2(DEPTH) bits.
  - is_ctrl is computed from in_inst at enqueue time and stored.
  - count is a separate register.
- Reset, while rst=1 and immediately after:
  - rd_ptr=wr_ptr=0, count=0, out_valid=0, in_ready=1.
  - out_pc=0, out_inst=32'h00000013 (NOP), out_is_ctrl=0.
  - Array contents do not need a reset.
- Enqueue: in_valid && in_ready && !flush writes the entry at wr_ptr; wr_ptr advances by 1, wrapping modulo DEPTH.
- Dequeue: out_valid && out_ready && !flush advances rd_ptr by 1, wrapping modulo DEPTH.
- Count update:
  - count += enq - deq.
  - Simultaneous enq and deq leaves count unchanged, and both pointers advance.
- Latency: an entry enqueued at edge N is visible on the out_* ports after edge N. There is no combinational bypass from in_* to out_*.
- Output mux when empty: out_pc=0, out_inst=NOP, out_is_ctrl=0. When not empty the outputs show the head entry. Decode must not rely on out_pc/out_inst unless out_valid=1.
- Full (count==DEPTH):
  - in_ready=0, and in_valid is ignored.
  - Fetch must hold pc/inst stable until in_ready=1. The fetch pc increment must be gated by the in_valid && in_ready handshake.
- Empty: out_valid=0, and out_ready is ignored.
- Flush:
  - At the next edge, rd_ptr=wr_ptr=0 and count=0.
  - Any same-cycle enqueue is dropped and any same-cycle dequeue is not counted.
  - Flush has priority over both enq and deq.
- Reset mid-operation: asynchronous clear of pointers and count. All entries are lost and the outputs go to their reset values without waiting for a clock edge.
- Pointer wrap: DEPTH is a power of two, so natural overflow of the pointer width is the wrap. Full and empty are distinguished only by count.

Decomposition:
- Shared defines file, extending the existing one:
  - Opcode constants: OPC_JAL, OPC_JALR, OPC_BRANCH.
  - NOP encoding: INST_NOP = 32'h00000013.
  - Widths: XLEN/ILEN, reusing the existing PC_START define where needed.
- Sub-module rv_predecode: combinational inst -> is_ctrl. It is reused later by branch prediction. Everything else stays in if_id_queue.

Test Plan:
- Reset then idle: rst pulse with no traffic -> out_valid=0, in_ready=1, count=0, out_inst=32'h00000013, out_pc=0.
- Single pass: enqueue pc=0x80000000, inst=0x00000093 at edge N with out_ready=0 -> after N, out_valid=1, out_pc=0x80000000, out_inst=0x00000093, out_is_ctrl=0, count=1. Then out_ready=1 for one cycle -> count=0.
- Fill and backpressure: enqueue 5 sequential pcs 0x80000000+4k with out_ready=0 -> count=4, in_ready=0 after the 4th. The 5th is held until one dequeue, and order is preserved on drain (pcs ...00, 04, 08, 0C, 10).
- Simultaneous enq/deq at full and across wrap: steady stream with in_valid=out_ready=1 for 10 cycles -> count constant, pcs emerge in order through ptr wrap, no duplicates or loss.
- Flush priority: count=3, flush=1 with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0. The flushed-cycle pc never appears at the output.
- Predecode and async reset: enqueue JAL 0x0000006F, then BRANCH 0x00000063 -> out_is_ctrl=1 for each at the head. Assert rst between clock edges -> out_valid drops to 0 immediately, before the next rising edge.
